// File: rtl/clk_divider_bank.sv
// Bank of independent programmable 50%-duty clock dividers with per-channel
// rising-edge tick strobes, all registered on clk_in.
module clk_divider_bank #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 27,
  parameter int DEFAULT_HALF = 20000000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] divided_clk,
  output logic [NUM_CH-1:0] tick
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             restart;
    logic [CNT_W-1:0] last_cnt;

    // A programmed half-period of 0 behaves as 1 (divide-by-2), so the
    // terminal count is 0 in both cases.
    always_comb begin
      wr_hit   = cfg_we && (cfg_ch == 3'(c));
      restart  = sync || wr_hit;
      last_cnt = (half_q == '0) ? '0 : half_q - CNT_W'(1);
    end

    always_ff @(posedge clk_in) begin
      if (rst) begin
        half_q <= CNT_W'(DEFAULT_HALF);
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (wr_hit) begin
          half_q <= cfg_half;
        end
        if (restart) begin
          cnt_q  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (en[c]) begin
          if (cnt_q == last_cnt) begin
            cnt_q  <= '0;
            clk_q  <= ~clk_q;
            tick_q <= ~clk_q;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end

    assign divided_clk[c] = clk_q;
    assign tick[c]        = tick_q;
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed + randomized bench for clk_divider_bank; a phase-based reference
// model predicts {tick, divided_clk} for every edge into a scoreboard queue.
module tb_clk_divider_bank;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 27;
  localparam int DEF_H  = 5;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] divided_clk;
  logic [NUM_CH-1:0] tick;

  clk_divider_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_H)
  ) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .divided_clk(divided_clk), .tick(tick)
  );

  // clock
  always #5 clk_in = ~clk_in;

  // reference model: position within the 2H-cycle period since last restart
  int m_half [NUM_CH];
  int m_p    [NUM_CH];
  logic [NUM_CH-1:0] m_clk, m_tick;

  // scoreboard
  logic [2*NUM_CH-1:0] exp_q [$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  function automatic int eff_h(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_half[c] = DEF_H; m_p[c] = 0; m_tick[c] = 1'b0;
      end else begin
        if (cfg_we && cfg_ch == 3'(c)) m_half[c] = int'(cfg_half);
        if (sync || (cfg_we && cfg_ch == 3'(c))) begin
          m_p[c] = 0; m_tick[c] = 1'b0;
        end else if (en[c]) begin
          m_p[c]    = (m_p[c] + 1) % (2 * eff_h(m_half[c]));
          m_tick[c] = (m_p[c] == eff_h(m_half[c]));
        end else begin
          m_tick[c] = 1'b0;
        end
      end
      m_clk[c] = (m_p[c] >= eff_h(m_half[c]));
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one clock edge: predict, push, advance, pop, compare; strobes self-clear
  task automatic step();
    logic [2*NUM_CH-1:0] e;
    model_edge();
    exp_q.push_back({m_tick, m_clk});
    @(posedge clk_in);
    #1;
    cyc++;
    e = exp_q.pop_front();
    checks++;
    assert ({tick, divided_clk} === e) else begin
      fails++;
      $error("FAIL sb_cyc%0d observed tick/clk=%b expected=%b", cyc, {tick, divided_clk}, e);
    end
    rst = 1'b0; sync = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // counts edges until divided_clk[ch] rises, bounded at 50
  task automatic wait_rise(input int ch, input int exp_n, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!divided_clk[ch] && n < 50);
    check(tag, 32'(n), 32'(exp_n));
    check({tag, "_tick"}, 32'(tick[ch]), 32'd1);
  endtask

  task automatic write(input logic [2:0] ch, input int h);
    cfg_we = 1'b1; cfg_ch = ch; cfg_half = CNT_W'(h);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = '1; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
    @(negedge clk_in);

    // reset with default half 5: both channels rise 5 edges later, period 10
    step();
    check("reset_outputs", 32'({tick, divided_clk}), 32'd0);
    wait_rise(0, 5, "rise_after_reset");
    check("ch1_rise_with_ch0", 32'(divided_clk[1]), 32'd1);
    run(20);

    // reprogram ch1 to 3 while ch0 keeps running
    write(3'd1, 3);
    step();
    check("ch1_low_after_write", 32'(divided_clk[1]), 32'd0);
    wait_rise(1, 3, "ch1_rise_h3");
    run(12);

    // half 0 on ch0: divide-by-2
    write(3'd0, 0);
    step();
    wait_rise(0, 1, "ch0_rise_h0");
    run(6);

    // pause ch0 for 4 cycles mid-period: edge delayed by exactly 4
    write(3'd0, 5);
    step();
    run(2);
    en = 2'b10;
    run(4);
    check("ch0_frozen_low", 32'({tick[0], divided_clk[0]}), 32'd0);
    en = 2'b11;
    wait_rise(0, 3, "ch0_rise_after_pause");
    run(8);

    // sync plus write ch1=2, then a stray write to channel 7
    sync = 1'b1;
    write(3'd1, 2);
    step();
    check("sync_all_low", 32'(divided_clk), 32'd0);
    write(3'd7, 1);
    step();
    wait_rise(1, 1, "ch1_rise_h2");
    run(4);
    check("ch1_rise_again_h2", 32'(divided_clk[1]), 32'd1);
    run(6);

    // randomized enables and occasional writes
    for (int i = 0; i < 60; i++) begin
      en = NUM_CH'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) write(3'($urandom_range(0, 7)), $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) sync = 1'b1;
      step();
    end
    en = '1;
    write(3'd0, 5);
    step();

    // reset mid-period while ch0 is high
    n = 0;
    while (!divided_clk[0] && n < 50) begin
      step();
      n++;
    end
    check("ch0_high_before_rst", 32'(divided_clk[0]), 32'd1);
    step();
    rst = 1'b1;
    step();
    check("rst_mid_period", 32'({tick, divided_clk}), 32'd0);
    wait_rise(1, 5, "default_half_restored");
    check("ch0_rise_default", 32'(divided_clk[0]), 32'd1);
    run(12);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/clk_divider_bank.md
# clk_divider_bank

Bank of `NUM_CH` independent programmable clock dividers driven from the 40 MHz board clock. Each channel produces a 50 %-duty divided clock and a one-cycle tick strobe aligned to that clock's rising edge. Each channel's half-period can be reprogrammed at run time. The bank supplies the slow clocks and enables used by the lock's display multiplexing, blink, and timeout logic. All outputs are registered and synchronous to `clk_in`.

## Interface
- `NUM_CH`, 2: number of divider channels (1..8).
- `CNT_W`, 27: width of the half-period and counter registers.
- `DEFAULT_HALF`, 20000000: half-period loaded into every channel at reset. At 40 MHz this gives a 1 Hz output.

Ports:
- `clk_in`  in  1  system clock (40 MHz).
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `en`  in  NUM_CH  per-channel count enable.
- `sync`  in  1  phase-restart strobe for all channels.
- `cfg_we`  in  1  half-period write strobe.
- `cfg_ch`  in  3  channel index for the write.
- `cfg_half`  in  CNT_W  new half-period, in `clk_in` cycles.
- `divided_clk`  out  NUM_CH  per-channel divided clock.
- `tick`  out  NUM_CH  per-channel one-cycle strobe, high on the cycle `divided_clk` rises.

## Operation
- Per-channel state:
  - `half[c]` (CNT_W bits)
  - `cnt[c]` (CNT_W bits)
  - `divided_clk[c]`
  - `tick[c]`
- Reset (`rst`=1 at a clock edge):
  - `half[c]`=DEFAULT_HALF
  - `cnt[c]`=0
  - `divided_clk`=0
  - `tick`=0
  - Reset overrides every other input.
- Effective half-period `H = (half[c]==0) ? 1 : half[c]`. A value of 0 therefore means divide-by-2.
- Counting, when `en[c]`=1 and no restart applies to channel c:
  - If `cnt[c]==H-1`: `cnt[c]`<=0 and `divided_clk[c]` toggles. `tick[c]`<=1 only when the toggle is 0->1.
  - Otherwise `cnt[c]` increments and `tick[c]`<=0.
- `en[c]`=0: `cnt[c]` and `divided_clk[c]` hold, and `tick[c]`<=0.
- Write (`cfg_we`=1 and `cfg_ch<NUM_CH`):
  - `half[cfg_ch]`<=cfg_half.
  - That channel restarts: `cnt`<=0, `divided_clk`<=0, `tick`<=0.
  - Other channels are unaffected.
- A write with `cfg_ch>=NUM_CH` is ignored entirely.
- `sync`=1: every channel restarts (`cnt`<=0, `divided_clk`<=0, `tick`<=0). `half` registers keep their values.
- `sync` and a valid `cfg_we` in the same cycle: both apply. The written channel takes the new half-period and all channels restart.
- A restart takes precedence over `en`. It applies even when `en[c]`=0.
- Counter arithmetic is unsigned CNT_W bits. `cnt` never exceeds H-1, so no wrap-around occurs.
- Reducing `half` below the current `cnt` cannot strand the counter, because every write clears `cnt`.

## Timing
- Restart means reset, sync, or a write. Let the restart be sampled at edge k, with `en[c]`=1 from then on.
  - `divided_clk[c]` rises at edge k+H and `tick[c]` is high for the single cycle following edge k+H.
  - `divided_clk[c]` falls at edge k+2H.
  - Steady state: period 2H cycles, high for exactly H cycles, one `tick` per period.
- Output frequency is f_clk/(2H). DEFAULT_HALF=20000000 gives 1 Hz; H=1 gives 20 MHz.
- Latency from `cfg_we` to the new rate: the first rising edge under the new H is H cycles after the write edge.
- Disabling `en[c]` at the edge where a toggle would occur suppresses that toggle. Re-enabling resumes from the held `cnt` value, so the pause delays the phase by exactly the number of disabled cycles.
- `tick` never asserts in two consecutive cycles, except when H=1, where it asserts every second cycle.
- `rst` asserted mid-period forces all outputs to 0 at the next edge.

## Test plan
- Reset with DEFAULT_HALF overridden to 5 and NUM_CH=2: both `divided_clk` rise 5 cycles after `rst` falls and have period 10. `tick` is high for 1 cycle per period, coincident with the rise.
- Write ch1 with `cfg_half`=3 while ch0 runs at 5: ch1 restarts low, rises 3 cycles later, period 6. Ch0 phase is unchanged.
- Write `cfg_half`=0 to ch0: `divided_clk[0]` toggles every cycle (period 2) and `tick[0]` is high every other cycle.
- Hold `en[0]` low for 4 cycles mid-period: `divided_clk[0]` and its count freeze, `tick[0]`=0, and the next edge is delayed by exactly 4 cycles.
- Assert `sync` together with a write of `cfg_half`=2 to ch1 and `cfg_ch`=7 stray writes:
  - Both channels go low and realign.
  - Ch1 then runs at period 4.
  - The out-of-range write changes nothing.
- Assert `rst` for one cycle mid-period with `divided_clk`=1: all outputs read 0 after the next edge, and `half` returns to DEFAULT_HALF.
